// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the round-robin UART transmit arbiter.
//   - Line levels for the frame format used by uart_rx: the line idles low,
//     the start bit is high, 8 data bits are sent LSB first, the stop bit is low.
//   - State encoding for the transmit sequencer.
//   - rr_inc: advances a requester index by one, wrapping at n-1.
package uart_tx_arbiter_pkg;

  localparam logic UART_IDLE      = 1'b0;
  localparam logic UART_START     = 1'b1;
  localparam logic UART_STOP      = 1'b0;
  localparam int   UART_DATA_BITS = 8;

  // Width of owner / round-robin pointer; covers up to 8 requesters.
  localparam int OWNER_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_GAP   = 3'd4
  } tx_state_e;

  // Next requester index after idx, modulo n.
  function automatic logic [OWNER_W-1:0] rr_inc(input logic [OWNER_W-1:0] idx,
                                                input int n);
    if (int'(idx) >= n - 1) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_shift.sv
// uart_tx_shift: frame sequencer and serialiser for one byte.
// A load pulse while idle captures byte_i and runs the frame
// START (1 bit), DATA (8 bits, LSB first), STOP (1 bit), then GAP idle-low bits.
// The line output is registered: tx_q always carries the level of the state
// that is current in the same cycle.
// Ports:
//   clk     in   bit clock, all logic on posedge
//   reset   in   synchronous, active-low
//   load_i  in   take byte_i and start a frame (only honoured while idle)
//   byte_i  in   byte to send
//   tx_o    out  serial line
//   busy_o  out  1 in START, DATA, STOP and GAP
//   idle_o  out  1 in IDLE: sequencer done and ready for the next load
module uart_tx_shift
  import uart_tx_arbiter_pkg::*;
#(
  parameter int GAP = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       idle_o
);

  // Last value of the gap counter; unused when GAP is 0 since GAP is skipped.
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  tx_state_e  state_q, state_d;
  logic [2:0] bit_cnt_q;
  logic [3:0] gap_cnt_q;
  logic [7:0] shift_q;
  logic       tx_q, tx_d;

  // State register, counters and the registered line
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      tx_q      <= UART_IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      bit_cnt_q <= (state_q == ST_DATA) ? bit_cnt_q + 3'd1 : 3'd0;
      gap_cnt_q <= (state_q == ST_GAP)  ? gap_cnt_q + 4'd1 : 4'd0;
    end
  end

  // Data register carries no reset: it is only read in DATA, which is always
  // entered through a load. Each edge into DATA puts shift_q[0] on the line
  // and exposes the next bit.
  always_ff @(posedge clk) begin
    if (load_i && state_q == ST_IDLE) begin
      shift_q <= byte_i;
    end else if (state_d == ST_DATA) begin
      shift_q <= {1'b0, shift_q[7:1]};
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (load_i) state_d = ST_START;
      ST_START: state_d = ST_DATA;
      ST_DATA:  if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) state_d = ST_STOP;
      ST_STOP:  state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic: the line level is decoded from the state being entered so
  // that the registered tx lines up with the state it belongs to.
  always_comb begin
    tx_d = UART_IDLE;
    case (state_d)
      ST_START: tx_d = UART_START;
      ST_DATA:  tx_d = shift_q[0];
      ST_STOP:  tx_d = UART_STOP;
      default:  tx_d = UART_IDLE;
    endcase
  end

  assign tx_o   = tx_q;
  assign busy_o = (state_q != ST_IDLE);
  assign idle_o = (state_q == ST_IDLE);

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one serial transmit line among N byte requesters
// using round-robin arbitration. While the line is idle the first requesting
// index at or after rr_ptr wins; its byte is taken on that edge, ack pulses for
// that cycle, and the frame is sent by uart_tx_shift.
// Ports:
//   clk    in   bit clock, all logic on posedge
//   reset  in   synchronous, active-low
//   req    in   N     req[i]=1: requester i offers data[8*i+7:8*i]
//   data   in   8*N   packed request bytes
//   ack    out  N     one-cycle, one-hot pulse for the requester whose byte is taken
//   owner  out  3     requester being sent (valid while busy)
//   busy   out  1     high from the cycle after ack until the frame incl. gap ends
//   tx     out  1     serial line
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int GAP = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [8*N-1:0]     data,
  output logic [N-1:0]       ack,
  output logic [OWNER_W-1:0] owner,
  output logic               busy,
  output logic               tx
);

  logic [OWNER_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [OWNER_W-1:0] owner_q;
  logic [OWNER_W-1:0] win_idx;
  logic [N-1:0]       req_rot;
  logic               grant_vld;
  logic               take;
  logic               line_idle;
  logic [7:0]         win_byte;

  // Rotate requests so bit 0 is the requester at rr_ptr; the first set bit
  // of the rotated vector is the winner, mapped back modulo N.
  always_comb begin
    req_rot   = N'({req, req} >> rr_ptr_q);
    grant_vld = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!grant_vld && req_rot[k]) begin
        grant_vld = 1'b1;
        win_idx   = OWNER_W'((int'(rr_ptr_q) + k) % N);
      end
    end
  end

  always_comb begin
    win_byte = '0;
    for (int k = 0; k < N; k++) begin
      if (OWNER_W'(k) == win_idx) win_byte = data[8*k +: 8];
    end
  end

  // A grant happens only while the sequencer is idle and out of reset, which
  // keeps ack silent during reset and while a frame is on the line.
  assign take     = reset && line_idle && grant_vld;
  assign ack      = take ? (N'(1) << win_idx) : '0;
  assign rr_ptr_d = rr_inc(win_idx, N);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else if (take) begin
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= win_idx;
    end
  end

  assign owner = owner_q;

  uart_tx_shift #(
    .GAP(GAP)
  ) u_shift (
    .clk   (clk),
    .reset (reset),
    .load_i(take),
    .byte_i(win_byte),
    .tx_o  (tx),
    .busy_o(busy),
    .idle_o(line_idle)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req0, ack0, req3, ack3;
  logic [31:0] data0, data3;
  logic [2:0]  owner0, owner3;
  logic        busy0, tx0, busy3, tx3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Observed traffic on dut0
  logic [3:0] ack_q[$];
  int         ackcyc_q[$];
  logic [3:0] bo_q[$];     // {busy, owner} one cycle after each ack
  logic [8:0] rx_q[$];     // {stop bit, data byte} decoded from tx0
  // Expected traffic on dut0
  logic [3:0] exp_ack_q[$];
  logic [2:0] exp_own_q[$];
  logic [8:0] exp_frm_q[$];

  uart_tx_arbiter #(.N(4), .GAP(0)) dut0 (
    .clk(clk), .reset(rst_n), .req(req0), .data(data0),
    .ack(ack0), .owner(owner0), .busy(busy0), .tx(tx0)
  );

  uart_tx_arbiter #(.N(4), .GAP(3)) dut3 (
    .clk(clk), .reset(rst_n), .req(req3), .data(data3),
    .ack(ack3), .owner(owner3), .busy(busy3), .tx(tx3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // Ack monitor: logs each ack and the {busy, owner} seen in the next cycle.
  initial begin : ack_mon
    bit pend;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        bo_q.push_back({busy0, owner0});
        pend = 1'b0;
      end
      if (ack0 !== 4'b0000) begin
        ack_q.push_back(ack0);
        ackcyc_q.push_back(cyc);
        pend = 1'b1;
      end
    end
  end

  // Receiver model: idle low, start high, 8 bits LSB first, then stop.
  initial begin : rx_mon
    int         st;
    int         nb;
    logic [7:0] sh;
    st = 0; nb = 0; sh = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        st = 0;
      end else begin
        case (st)
          0: if (tx0 === 1'b1) begin st = 1; nb = 0; end
          1: begin
            sh = {tx0, sh[7:1]};
            nb++;
            if (nb == 8) st = 2;
          end
          default: begin
            rx_q.push_back({tx0, sh});
            st = 0;
          end
        endcase
      end
    end
  end

  task automatic clear_queues();
    ack_q.delete(); ackcyc_q.delete(); bo_q.delete(); rx_q.delete();
    exp_ack_q.delete(); exp_own_q.delete(); exp_frm_q.delete();
  endtask

  task automatic wait_acks(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (ack_q.size() >= n) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (rx_q.size() >= n) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 4'hF; data0 = 32'hFFFF_FFFF;
    req3 = 4'hF; data3 = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (tx0 !== 1'b0 || ack0 !== 4'b0 || busy0 !== 1'b0 || owner0 !== 3'd0) begin
        errors++;
        $display("FAIL reset_dut0 cycle %0d: got tx=%b ack=%b busy=%b owner=%0d, want all 0",
                 i, tx0, ack0, busy0, owner0);
      end
      checks++;
      if (tx3 !== 1'b0 || ack3 !== 4'b0 || busy3 !== 1'b0) begin
        errors++;
        $display("FAIL reset_dut3 cycle %0d: got tx=%b ack=%b busy=%b, want all 0",
                 i, tx3, ack3, busy3);
      end
    end
    @(posedge clk); #1;
    req0 = '0; req3 = '0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [3:0] e_ack, g_ack;
    logic [2:0] e_own;
    logic [8:0] e_frm, g_frm;
    logic [3:0] g_bo;
    clear_queues();
    for (int k = 0; k < 5; k++) begin
      exp_ack_q.push_back(4'b0001 << (k % 4));
      exp_own_q.push_back(3'(k % 4));
      exp_frm_q.push_back({1'b0, 8'h10 + 8'(k % 4)});
    end
    data0 = 32'h1312_1110;
    req0  = 4'hF;
    wait_acks(5, 80, ok);
    req0 = '0;
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_ack_timeout: got %0d acks, want 5", ack_q.size()); end
    wait_frames(5, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_frame_timeout: got %0d frames, want 5", rx_q.size()); end
    for (int k = 1; k < ackcyc_q.size(); k++) begin
      checks++;
      if (ackcyc_q[k] - ackcyc_q[k-1] != 11) begin
        errors++;
        $display("FAIL rr_spacing ack %0d: got %0d cycles, want 11", k, ackcyc_q[k] - ackcyc_q[k-1]);
      end
    end
    while (exp_ack_q.size() > 0) begin
      e_ack = exp_ack_q.pop_front();
      e_own = exp_own_q.pop_front();
      e_frm = exp_frm_q.pop_front();
      checks++;
      if (ack_q.size() == 0) begin
        errors++; $display("FAIL rr_ack: got none, want %b", e_ack);
      end else begin
        g_ack = ack_q.pop_front();
        if (g_ack !== e_ack) begin errors++; $display("FAIL rr_ack: got %b, want %b", g_ack, e_ack); end
      end
      checks++;
      if (bo_q.size() == 0) begin
        errors++; $display("FAIL rr_owner: got none, want busy=1 owner=%0d", e_own);
      end else begin
        g_bo = bo_q.pop_front();
        if (g_bo !== {1'b1, e_own}) begin
          errors++; $display("FAIL rr_owner: got busy/owner %b, want %b", g_bo, {1'b1, e_own});
        end
      end
      checks++;
      if (rx_q.size() == 0) begin
        errors++; $display("FAIL rr_frame: got none, want %h", e_frm);
      end else begin
        g_frm = rx_q.pop_front();
        if (g_frm !== e_frm) begin errors++; $display("FAIL rr_frame: got %h, want %h", g_frm, e_frm); end
      end
    end
  endtask

  task automatic test_single_byte();
    bit         ok;
    bit         found;
    int         ack_extra;
    logic [9:0] seq;
    logic [8:0] g_frm, e_frm;
    logic [2:0] e_own;
    logic [3:0] g_bo;
    clear_queues();
    exp_frm_q.push_back({1'b0, 8'hA5});
    exp_own_q.push_back(3'd2);
    data0 = 32'h00A5_0000;
    req0  = 4'b0100;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ack0 !== 4'b0000) begin found = 1'b1; break; end
    end
    checks++;
    if (!found || ack0 !== 4'b0100) begin
      errors++; $display("FAIL single_ack: got %b, want 0100", ack0);
    end
    @(posedge clk); #1;
    req0 = '0; data0 = '0;
    seq = '0; ack_extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seq = {tx0, seq[9:1]};
      if (ack0 !== 4'b0000) ack_extra++;
    end
    checks++;
    if (seq !== 10'b0101001011) begin
      errors++; $display("FAIL single_tx_seq (bit0 first): got %b, want 0101001011", seq);
    end
    checks++;
    if (ack_extra != 0) begin errors++; $display("FAIL single_ack_width: got %0d extra ack cycles, want 0", ack_extra); end
    wait_frames(1, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_frame_timeout: got 0 frames, want 1"); end
    e_frm = exp_frm_q.pop_front();
    e_own = exp_own_q.pop_front();
    checks++;
    if (rx_q.size() == 0) begin
      errors++; $display("FAIL single_frame: got none, want %h", e_frm);
    end else begin
      g_frm = rx_q.pop_front();
      if (g_frm !== e_frm) begin errors++; $display("FAIL single_frame: got %h, want %h", g_frm, e_frm); end
    end
    checks++;
    if (bo_q.size() == 0) begin
      errors++; $display("FAIL single_owner: got none, want owner %0d", e_own);
    end else begin
      g_bo = bo_q.pop_front();
      if (g_bo !== {1'b1, e_own}) begin
        errors++; $display("FAIL single_owner: got busy/owner %b, want %b", g_bo, {1'b1, e_own});
      end
    end
  endtask

  task automatic test_skip_wrap();
    bit ok;
    logic [3:0] e_ack, g_ack, g_bo;
    logic [2:0] e_own;
    logic [8:0] e_frm, g_frm;
    clear_queues();
    exp_ack_q.push_back(4'b0001); exp_own_q.push_back(3'd0); exp_frm_q.push_back({1'b0, 8'h3C});
    exp_ack_q.push_back(4'b0100); exp_own_q.push_back(3'd2); exp_frm_q.push_back({1'b0, 8'hC3});
    exp_ack_q.push_back(4'b0001); exp_own_q.push_back(3'd0); exp_frm_q.push_back({1'b0, 8'h3C});
    data0 = 32'h00C3_003C;
    req0  = 4'b0101;
    wait_acks(3, 60, ok);
    req0 = '0;
    checks++;
    if (!ok) begin errors++; $display("FAIL skip_ack_timeout: got %0d acks, want 3", ack_q.size()); end
    wait_frames(3, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL skip_frame_timeout: got %0d frames, want 3", rx_q.size()); end
    while (exp_ack_q.size() > 0) begin
      e_ack = exp_ack_q.pop_front();
      e_own = exp_own_q.pop_front();
      e_frm = exp_frm_q.pop_front();
      checks++;
      if (ack_q.size() == 0) begin
        errors++; $display("FAIL skip_ack: got none, want %b", e_ack);
      end else begin
        g_ack = ack_q.pop_front();
        if (g_ack !== e_ack) begin errors++; $display("FAIL skip_ack: got %b, want %b", g_ack, e_ack); end
      end
      checks++;
      if (bo_q.size() == 0) begin
        errors++; $display("FAIL skip_owner: got none, want owner %0d", e_own);
      end else begin
        g_bo = bo_q.pop_front();
        if (g_bo !== {1'b1, e_own}) begin
          errors++; $display("FAIL skip_owner: got busy/owner %b, want %b", g_bo, {1'b1, e_own});
        end
      end
      checks++;
      if (rx_q.size() == 0) begin
        errors++; $display("FAIL skip_frame: got none, want %h", e_frm);
      end else begin
        g_frm = rx_q.pop_front();
        if (g_frm !== e_frm) begin errors++; $display("FAIL skip_frame: got %h, want %h", g_frm, e_frm); end
      end
    end
  endtask

  task automatic test_midframe_gap();
    bit          found;
    int          ack_during;
    logic [13:0] txv, e_txv;
    logic [3:0]  ack_last;
    logic        busy_gap, busy_last;
    logic [2:0]  own0;
    e_txv = {5'b00000, 8'h5A, 1'b1};
    data3 = 32'h0000_005A;
    req3  = 4'b0001;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ack3 !== 4'b0000) begin found = 1'b1; break; end
    end
    checks++;
    if (!found || ack3 !== 4'b0001) begin
      errors++; $display("FAIL mid_ack: got %b, want 0001", ack3);
    end
    @(posedge clk); #1;
    req3 = '0;
    txv = '0; ack_during = 0; ack_last = '0; busy_gap = 1'b0; busy_last = 1'b1; own0 = '0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      txv = {tx3, txv[13:1]};
      if (i < 13 && ack3 !== 4'b0000) ack_during++;
      if (i == 0) own0 = owner3;
      if (i == 12) busy_gap = busy3;
      if (i == 13) begin ack_last = ack3; busy_last = busy3; end
      if (i == 3) begin
        data3[7:0]  = 8'hFF;
        data3[15:8] = 8'h77;
        req3[1]     = 1'b1;
      end
    end
    checks++;
    if (txv !== e_txv) begin errors++; $display("FAIL mid_tx_seq (bit0 first): got %b, want %b", txv, e_txv); end
    checks++;
    if (ack_during != 0) begin errors++; $display("FAIL mid_ack_while_busy: got %0d ack cycles, want 0", ack_during); end
    checks++;
    if (own0 !== 3'd0) begin errors++; $display("FAIL mid_owner: got %0d, want 0", own0); end
    checks++;
    if (busy_gap !== 1'b1) begin errors++; $display("FAIL mid_busy_gap: got %b, want 1", busy_gap); end
    checks++;
    if (ack_last !== 4'b0010 || busy_last !== 1'b0) begin
      errors++; $display("FAIL mid_next_grant: got ack=%b busy=%b, want ack=0010 busy=0", ack_last, busy_last);
    end
    @(posedge clk); #1;
    req3 = '0;
  endtask

  task automatic test_reset_midframe();
    bit         ok;
    bit         found;
    logic       tx_bit3;
    logic [3:0] g_ack, g_bo;
    logic [8:0] g_frm, e_frm;
    clear_queues();
    data0 = 32'h0000_0F00;
    req0  = 4'b0010;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ack0 !== 4'b0000) begin found = 1'b1; break; end
    end
    checks++;
    if (!found || ack0 !== 4'b0010) begin
      errors++; $display("FAIL rstmid_ack: got %b, want 0010", ack0);
    end
    @(posedge clk); #1;
    req0 = '0;
    tx_bit3 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 4) tx_bit3 = tx0;
    end
    checks++;
    if (tx_bit3 !== 1'b1) begin errors++; $display("FAIL rstmid_bit3: got %b, want 1", tx_bit3); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (tx0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL rstmid_abort: got tx=%b busy=%b, want tx=0 busy=0", tx0, busy0);
    end
    checks++;
    if (owner0 !== 3'd0) begin errors++; $display("FAIL rstmid_owner: got %0d, want 0", owner0); end
    req0  = 4'hF;
    data0 = 32'hD4C3_B2A1;
    @(negedge clk);
    checks++;
    if (ack0 !== 4'b0000) begin errors++; $display("FAIL rstmid_ack_in_reset: got %b, want 0000", ack0); end
    checks++;
    if (rx_q.size() != 0) begin errors++; $display("FAIL rstmid_partial_frame: got %0d frames, want 0", rx_q.size()); end
    @(posedge clk); #1;
    clear_queues();
    e_frm = {1'b0, 8'hA1};
    rst_n = 1'b1;
    wait_acks(1, 20, ok);
    req0 = '0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rstmid_regrant_timeout: got 0 acks, want 1");
    end else begin
      g_ack = ack_q.pop_front();
      if (g_ack !== 4'b0001) begin errors++; $display("FAIL rstmid_regrant: got %b, want 0001", g_ack); end
    end
    wait_frames(1, 20, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rstmid_frame_timeout: got 0 frames, want 1");
    end else begin
      g_frm = rx_q.pop_front();
      if (g_frm !== e_frm) begin errors++; $display("FAIL rstmid_frame: got %h, want %h", g_frm, e_frm); end
    end
    checks++;
    if (bo_q.size() == 0) begin
      errors++; $display("FAIL rstmid_owner_after: got none, want busy=1 owner=0");
    end else begin
      g_bo = bo_q.pop_front();
      if (g_bo !== 4'b1000) begin errors++; $display("FAIL rstmid_owner_after: got %b, want 1000", g_bo); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = '0; data0 = '0; req3 = '0; data3 = '0;
    test_reset();
    test_round_robin();
    test_single_byte();
    test_skip_wrap();
    test_midframe_gap();
    test_reset_midframe();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
